riscv_parcel_queue: RTL and testbench
=====================================

Name: riscv_parcel_queue

Overview:
- Downstream neighbour of the instruction-cache hit stage; consumes its parcel_o / parcel_valid_o / error / misaligned / pagefault outputs.
- Compacts the valid 16-bit parcels of each fetched word into a circular parcel FIFO.
- Presents the two oldest parcels, with per-parcel status, to the pre-decode/decode stage.
- Throttles fetch with a registered almost-full flag so no parcel is ever lost.

Parameters:
- XLEN, 32, fetch word width (32 or 64).
- PARCEL_SIZE, 16, parcel width in bits.
- DEPTH, 8, queue capacity in parcels. Power of 2, >= 2*XLEN/PARCEL_SIZE.
- localparam PPW = XLEN/PARCEL_SIZE, parcels per word.
- localparam CNT_BITS = $clog2(DEPTH+1).
- localparam PTR_BITS = $clog2(DEPTH).

Ports:
- rst_ni  in  1  asynchronous, active-low reset.
- clk_i  in  1  clock.
- flush_i  in  1  pipe flush; empties the queue.
- parcel_i  in  XLEN  fetched word; parcel k is bits [k*PARCEL_SIZE +: PARCEL_SIZE].
- parcel_valid_i  in  PPW  per-parcel valid. Set bits are contiguous and run from some index j up to PPW-1.
- parcel_error_i  in  1  bus/PMA/PMP error for the whole word.
- parcel_misaligned_i  in  1  misaligned fetch for the whole word.
- parcel_pagefault_i  in  1  page fault for the whole word.
- almost_full_o  out  1  registered; upstream must not issue new fetches while set.
- q_parcel_o  out  2*PARCEL_SIZE  {parcel at head+1, parcel at head}.
- q_valid_o  out  2  bit0 is set when count>=1; bit1 is set when count>=2.
- q_error_o  out  2  error flag per output parcel.
- q_misaligned_o  out  2  misaligned flag per output parcel.
- q_pagefault_o  out  2  pagefault flag per output parcel.
- rd_i  in  1  consume parcels.
- rd_cnt_i  in  1  0 means consume 1 parcel; 1 means consume 2 parcels.
- count_o  out  CNT_BITS  current number of stored parcels.

Behaviour:
- Reset (asynchronous):
  - head=0, tail=0, count=0.
  - almost_full_o=0.
  - Outputs fall through from storage, so q_valid_o=2'b00. Storage contents are don't-care.
- Storage: DEPTH entries, each {pagefault, misaligned, error, parcel}.
  - The word's status flags are replicated onto every parcel written from that word.
- Write:
  - nwr = popcount(parcel_valid_i).
  - Valid parcels are written in ascending index order to tail, tail+1, ... (mod DEPTH).
  - tail advances by nwr.
  - The write happens even when the parcel has error/misaligned/pagefault set; the flags travel with it.
- Read (first-word fall-through):
  - Outputs are driven combinationally from head and head+1 (mod DEPTH).
  - nrd = rd_i ? rd_cnt_i+1 : 0.
  - If nrd > count, the read is ignored: no pop occurs and the sticky simulation assertion fires.
  - On a legal read, head advances by nrd.
- Count and latency:
  - count_next = count + nwr - nrd. Simultaneous read and write are allowed.
  - A written parcel is visible on q_* the cycle after the write; there is no same-cycle bypass.
- Overflow protection:
  - almost_full_o is registered as (DEPTH - count_next) < 2*PPW.
  - This gives one cycle of slack for a fetch already in the hit stage.
  - A write with count + nwr - nrd > DEPTH is a protocol violation. The bench asserts it; the RTL saturates by dropping the excess parcels.
- Flush:
  - flush_i has priority over same-cycle read and write.
  - Next cycle: head=tail=count=0, almost_full_o=0, q_valid_o=0.
- Wrap-around: pointers are PTR_BITS wide and wrap naturally. Entries at DEPTH-1 and 0 form a legal output pair.
- Width rule: head+1 and tail+k are computed mod DEPTH. count never exceeds DEPTH.
- Reset mid-operation: all state returns immediately to reset values; queued parcels are lost.

Decomposition:
- Shared package riscv_cache_pkg: add a parcel_entry_t struct {pagefault, misaligned, error, parcel[PARCEL_SIZE-1:0]} and a popcount function.
- Sub-module riscv_parcel_compact (combinational): maps parcel_valid_i/parcel_i into a packed array of nwr entries plus nwr.
- The queue itself stays in the top module.

Test Plan:
- XLEN=32, write parcel_i=32'hBBBB_AAAA, valid=2'b11 into an empty queue.
  - Next cycle: q_parcel_o=32'hBBBB_AAAA, q_valid_o=2'b11, count_o=2.
- Write valid=2'b10, parcel_i=32'h1234_xxxx into an empty queue.
  - count_o=1, q_parcel_o[15:0]=16'h1234, q_valid_o=2'b01.
- Fill to count=5: almost_full_o is set (8-5 < 4). Write 2 and read 2 in the same cycle.
  - count stays 5; almost_full_o stays 1. Read 2 with no write: count=3, almost_full_o=0.
- Drive the pointers so head=7 with 2 parcels stored (entries 7 and 0).
  - q_parcel_o = {entry0, entry7}. After rd_i with rd_cnt_i=1: head=1, count=0.
- Write with parcel_pagefault_i=1, valid=2'b11.
  - q_pagefault_o=2'b11, and the parcels are still delivered.
- With count=6, assert flush_i together with rd_i and a write.
  - Next cycle: count_o=0, q_valid_o=0, almost_full_o=0.
  - A subsequent write is read back from index 0.

Source files
------------

// File: rtl/riscv_cache_pkg.sv
// riscv_cache_pkg: shared parcel entry type and popcount helper for the fetch path
package riscv_cache_pkg;
  localparam int unsigned PARCEL_W = 16;
  typedef struct packed {
    logic                pagefault;
    logic                misaligned;
    logic                error;
    logic [PARCEL_W-1:0] parcel;
  } parcel_entry_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount = popcount + {3'b000, v[i]};
  endfunction
endpackage

// File: rtl/riscv_parcel_compact.sv
// riscv_parcel_compact: packs the valid parcels of a fetched word into entries 0..nwr-1
module riscv_parcel_compact
  import riscv_cache_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PARCEL_SIZE = PARCEL_W,
  localparam int PPW = XLEN / PARCEL_SIZE,
  localparam int NW_BITS = $clog2(PPW + 1)
) (
  input  logic [XLEN-1:0]          parcel_i,
  input  logic [PPW-1:0]           parcel_valid_i,
  input  logic                     error_i,
  input  logic                     misaligned_i,
  input  logic                     pagefault_i,
  output parcel_entry_t [PPW-1:0]  ent_o,
  output logic [NW_BITS-1:0]       nwr_o
);
  // valid bits are contiguous up to PPW-1, so entry k comes from word parcel PPW-nwr+k
  always_comb begin
    nwr_o = NW_BITS'(popcount(8'(parcel_valid_i)));
    ent_o = '0;
    for (int k = 0; k < PPW; k++) begin
      int idx;
      idx = (k + PPW - int'(nwr_o)) % PPW;
      ent_o[k].pagefault = pagefault_i;
      ent_o[k].misaligned = misaligned_i;
      ent_o[k].error = error_i;
      ent_o[k].parcel = parcel_i[idx*PARCEL_SIZE +: PARCEL_SIZE];
    end
  end
endmodule

// File: rtl/riscv_parcel_queue.sv
// riscv_parcel_queue: circular parcel FIFO between the I-cache hit stage and decode
module riscv_parcel_queue
  import riscv_cache_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PARCEL_SIZE = 16,
  parameter int DEPTH = 8,
  localparam int PPW = XLEN / PARCEL_SIZE,
  localparam int CNT_BITS = $clog2(DEPTH + 1),
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                     rst_ni,
  input  logic                     clk_i,
  input  logic                     flush_i,
  input  logic [XLEN-1:0]          parcel_i,
  input  logic [PPW-1:0]           parcel_valid_i,
  input  logic                     parcel_error_i,
  input  logic                     parcel_misaligned_i,
  input  logic                     parcel_pagefault_i,
  output logic                     almost_full_o,
  output logic [2*PARCEL_SIZE-1:0] q_parcel_o,
  output logic [1:0]               q_valid_o,
  output logic [1:0]               q_error_o,
  output logic [1:0]               q_misaligned_o,
  output logic [1:0]               q_pagefault_o,
  input  logic                     rd_i,
  input  logic                     rd_cnt_i,
  output logic [CNT_BITS-1:0]      count_o
);
  localparam int NW_BITS = $clog2(PPW + 1);
  parcel_entry_t           mem_q [DEPTH];
  parcel_entry_t [PPW-1:0] ent;
  logic [NW_BITS-1:0]      nwr;
  logic [PTR_BITS-1:0]     head_q, head_d, tail_q, tail_d, head1;
  logic [CNT_BITS-1:0]     count_q, count_d, nrd, nrd_e, nwr_e, space;
  logic                    almost_full_q, rd_ok;
  riscv_parcel_compact #(.XLEN(XLEN), .PARCEL_SIZE(PARCEL_SIZE)) u_compact (
    .parcel_i(parcel_i),
    .parcel_valid_i(parcel_valid_i),
    .error_i(parcel_error_i),
    .misaligned_i(parcel_misaligned_i),
    .pagefault_i(parcel_pagefault_i),
    .ent_o(ent),
    .nwr_o(nwr)
  );
  // next-state: over-reads are ignored, writes beyond capacity are dropped, flush wins
  always_comb begin
    nrd = CNT_BITS'({rd_i & rd_cnt_i, rd_i & ~rd_cnt_i});
    rd_ok = nrd <= count_q;
    nrd_e = rd_ok ? nrd : '0;
    space = CNT_BITS'(DEPTH) - count_q + nrd_e;
    nwr_e = CNT_BITS'(nwr) > space ? space : CNT_BITS'(nwr);
    count_d = flush_i ? '0 : count_q + nwr_e - nrd_e;
    head_d = flush_i ? '0 : head_q + PTR_BITS'(nrd_e);
    tail_d = flush_i ? '0 : tail_q + PTR_BITS'(nwr_e);
    head1 = head_q + PTR_BITS'(1);
  end
  // pointer, count and almost-full state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      almost_full_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      almost_full_q <= (CNT_BITS'(DEPTH) - count_d) < CNT_BITS'(2 * PPW);
    end
  end
  // parcel storage, written in ascending order from tail
  always_ff @(posedge clk_i) begin
    if (!flush_i)
      for (int k = 0; k < PPW; k++)
        if (CNT_BITS'(k) < nwr_e) mem_q[tail_q + PTR_BITS'(k)] <= ent[k];
  end
  assign q_parcel_o = {mem_q[head1].parcel, mem_q[head_q].parcel};
  assign q_valid_o = {count_q >= CNT_BITS'(2), count_q != '0};
  assign q_error_o = {mem_q[head1].error, mem_q[head_q].error};
  assign q_misaligned_o = {mem_q[head1].misaligned, mem_q[head_q].misaligned};
  assign q_pagefault_o = {mem_q[head1].pagefault, mem_q[head_q].pagefault};
  assign almost_full_o = almost_full_q;
  assign count_o = count_q;
  rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) rd_ok);
endmodule

// File: tb/tb_riscv_parcel_queue.sv
// tb_riscv_parcel_queue: directed self-checking bench for the parcel queue
module tb_riscv_parcel_queue;
  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, rd_i = 1'b0, rd_cnt_i = 1'b0;
  logic        err_i = 1'b0, mis_i = 1'b0, pf_i = 1'b0;
  logic [31:0] parcel_i = '0;
  logic [1:0]  parcel_valid_i = '0;
  logic        almost_full_o;
  logic [31:0] q_parcel_o;
  logic [1:0]  q_valid_o, q_error_o, q_misaligned_o, q_pagefault_o;
  logic [3:0]  count_o;
  int vectors = 0, miscompares = 0;
  riscv_parcel_queue #(.XLEN(32), .PARCEL_SIZE(16), .DEPTH(8)) dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .flush_i(flush_i),
    .parcel_i(parcel_i), .parcel_valid_i(parcel_valid_i),
    .parcel_error_i(err_i), .parcel_misaligned_i(mis_i), .parcel_pagefault_i(pf_i),
    .almost_full_o(almost_full_o), .q_parcel_o(q_parcel_o), .q_valid_o(q_valid_o),
    .q_error_o(q_error_o), .q_misaligned_o(q_misaligned_o), .q_pagefault_o(q_pagefault_o),
    .rd_i(rd_i), .rd_cnt_i(rd_cnt_i), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  // protocol guard: the bench must never overfill the queue
  always @(negedge clk_i) begin
    int pred;
    pred = int'(count_o) + int'(parcel_valid_i[0]) + int'(parcel_valid_i[1]) - (rd_i ? int'(rd_cnt_i) + 1 : 0);
    if (rst_ni && !flush_i)
      assert (pred <= 8) else begin
        miscompares++;
        $error("FAIL overflow observed=%0d expected<=8", pred);
      end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
    flush_i = 0; rd_i = 0; rd_cnt_i = 0; parcel_valid_i = '0; err_i = 0; mis_i = 0; pf_i = 0;
  endtask
  task automatic wr(input logic [31:0] d, input logic [1:0] v, input logic e, input logic m, input logic p);
    parcel_i = d; parcel_valid_i = v; err_i = e; mis_i = m; pf_i = p;
  endtask
  task automatic rd(input logic two);
    rd_i = 1; rd_cnt_i = two;
  endtask
  initial begin
    #12;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(q_valid_o), 0);
    chk("rst_af", 32'(almost_full_o), 0);
    rst_ni = 1;
    wr(32'hBBBB_AAAA, 2'b11, 0, 0, 0); cyc();
    chk("w2_parcel", q_parcel_o, 32'hBBBB_AAAA);
    chk("w2_valid", 32'(q_valid_o), 3);
    chk("w2_count", 32'(count_o), 2);
    chk("w2_af", 32'(almost_full_o), 0);
    rd(1); cyc();
    chk("r2_count", 32'(count_o), 0);
    chk("r2_valid", 32'(q_valid_o), 0);
    wr(32'h1234_5678, 2'b10, 0, 0, 0); cyc();
    chk("hi_count", 32'(count_o), 1);
    chk("hi_parcel", 32'(q_parcel_o[15:0]), 32'h1234);
    chk("hi_valid", 32'(q_valid_o), 1);
    wr(32'h0004_0003, 2'b11, 0, 0, 0); cyc();
    chk("c3_parcel", q_parcel_o, 32'h0003_1234);
    wr(32'h0006_0005, 2'b11, 0, 0, 0); cyc();
    chk("c5_count", 32'(count_o), 5);
    chk("c5_af", 32'(almost_full_o), 1);
    wr(32'h00F0_0077, 2'b11, 0, 0, 0); rd(1); cyc();
    chk("wr_rd_count", 32'(count_o), 5);
    chk("wr_rd_af", 32'(almost_full_o), 1);
    chk("wr_rd_parcel", q_parcel_o, 32'h0005_0004);
    rd(1); cyc();
    chk("r2b_count", 32'(count_o), 3);
    chk("r2b_af", 32'(almost_full_o), 0);
    chk("r2b_parcel", q_parcel_o, 32'h0077_0006);
    rd(0); cyc();
    chk("wrap_count", 32'(count_o), 2);
    chk("wrap_parcel", q_parcel_o, 32'h00F0_0077);
    chk("wrap_valid", 32'(q_valid_o), 3);
    rd(1); cyc();
    chk("wrap_drain_count", 32'(count_o), 0);
    chk("wrap_drain_valid", 32'(q_valid_o), 0);
    wr(32'hCAFE_BEEF, 2'b11, 0, 0, 1); cyc();
    chk("pf_flags", 32'(q_pagefault_o), 3);
    chk("pf_parcel", q_parcel_o, 32'hCAFE_BEEF);
    chk("pf_valid", 32'(q_valid_o), 3);
    chk("pf_err", 32'(q_error_o), 0);
    wr(32'hDDDD_0000, 2'b10, 1, 0, 0); cyc();
    chk("err_count", 32'(count_o), 3);
    rd(1); cyc();
    chk("err_parcel", 32'(q_parcel_o[15:0]), 32'hDDDD);
    chk("err_flag", 32'(q_error_o[0]), 1);
    chk("err_pf", 32'(q_pagefault_o[0]), 0);
    chk("err_valid", 32'(q_valid_o), 1);
    chk("err_rcount", 32'(count_o), 1);
    wr(32'h2222_1111, 2'b11, 0, 1, 0); cyc();
    chk("mis_count", 32'(count_o), 3);
    chk("mis_parcel", q_parcel_o, 32'h1111_DDDD);
    chk("mis_flags", 32'(q_misaligned_o), 2);
    wr(32'hFFFF_FFFF, 2'b00, 0, 0, 0); cyc();
    chk("nowr_count", 32'(count_o), 3);
    wr(32'h4444_3333, 2'b11, 0, 0, 0); cyc();
    wr(32'h5555_0000, 2'b10, 0, 0, 0); cyc();
    chk("c6_count", 32'(count_o), 6);
    chk("c6_af", 32'(almost_full_o), 1);
    wr(32'h7777_6666, 2'b11, 0, 0, 0); rd(1); flush_i = 1; cyc();
    chk("fl_count", 32'(count_o), 0);
    chk("fl_valid", 32'(q_valid_o), 0);
    chk("fl_af", 32'(almost_full_o), 0);
    wr(32'h9999_8888, 2'b11, 0, 0, 0); cyc();
    chk("postfl_parcel", q_parcel_o, 32'h9999_8888);
    chk("postfl_count", 32'(count_o), 2);
    wr(32'hAAAA_BBBB, 2'b11, 0, 0, 0); cyc();
    wr(32'hCCCC_DDDD, 2'b11, 0, 0, 0); cyc();
    chk("pre_rst_af", 32'(almost_full_o), 1);
    #2; rst_ni = 0; #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_af", 32'(almost_full_o), 0);
    chk("arst_valid", 32'(q_valid_o), 0);
    #3; rst_ni = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
